hack_memory_map: RTL and testbench

Parametrised successor to the Hack data-memory block. It decodes one CPU address space into general RAM, a screen frame buffer, a buffered keyboard port and a keyboard status register. Reads are registered with one-cycle latency. A second read-only port lets a display controller scan the frame buffer. It sits between the Hack CPU data port and the RAM, screen and keyboard peripherals.

---
 rtl/hack_memory_map_pkg.sv | 51 +++++
 rtl/hack_memory_map_kbd_fifo.sv | 65 ++++++
 rtl/hack_memory_map.sv | 111 +++++++++++
 tb/tb_hack_memory_map.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hack_memory_map_pkg.sv
// rtl/hack_memory_map_pkg.sv - shared map constants, region decode and status layout for hack_memory_map
package hack_memory_map_pkg;

    // Default Hack geometry; the top level recomputes the map from its own parameters.
    localparam int DEF_DATA_W       = 16;
    localparam int DEF_ADDR_W       = 15;
    localparam int DEF_RAM_WORDS    = 16384;
    localparam int DEF_SCREEN_WORDS = 8192;
    localparam int DEF_KBD_DEPTH    = 8;

    localparam int SCR_BASE  = DEF_RAM_WORDS;
    localparam int KBD_ADDR  = SCR_BASE + DEF_SCREEN_WORDS;
    localparam int STAT_ADDR = KBD_ADDR + 1;

    // Status word: count occupies the low bits, overflow the top bit.
    localparam int STAT_CNT_LSB = 0;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_SCREEN,
        REG_KBD,
        REG_STAT,
        REG_NONE
    } region_e;

    function automatic int stat_ovf_bit(input int data_w);
        return data_w - 1;
    endfunction

    // Region boundaries follow the sizes passed in, so a non-default
    // instance decodes its own map without touching this package.
    function automatic region_e decode_region(
        input logic [31:0] addr,
        input logic [31:0] ram_words,
        input logic [31:0] screen_words
    );
        logic [31:0] kbd;
        kbd = ram_words + screen_words;
        if (addr < ram_words)
            return REG_RAM;
        else if (addr < kbd)
            return REG_SCREEN;
        else if (addr == kbd)
            return REG_KBD;
        else if (addr == kbd + 32'd1)
            return REG_STAT;
        else
            return REG_NONE;
    endfunction

endpackage

// File: rtl/hack_memory_map_kbd_fifo.sv
// rtl/hack_memory_map_kbd_fifo.sv - keyboard code FIFO with count, full/empty and sticky overflow
module hack_memory_map_kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     ovf_clr,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;
    logic [CNT_W-1:0] count_next;

    assign do_pop     = pop && (count != '0);
    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign do_push    = push && ((count != FULL_CNT) || do_pop);
    assign count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == FULL_CNT);
            // A dropped code wins over a same-cycle clear so the loss is never hidden.
            if (push && !do_push)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/hack_memory_map.sv
// rtl/hack_memory_map.sv - Hack data memory: RAM, dual-read screen, keyboard FIFO and status decode
module hack_memory_map
    import hack_memory_map_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int RAM_WORDS    = DEF_RAM_WORDS,
    parameter int SCREEN_WORDS = DEF_SCREEN_WORDS,
    parameter int KBD_DEPTH    = DEF_KBD_DEPTH
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [DATA_W-1:0]               in,
    input  logic [ADDR_W-1:0]               address,
    input  logic                            load,
    output logic [DATA_W-1:0]               out,
    output logic                            addr_err,
    input  logic [$clog2(SCREEN_WORDS)-1:0] scr_addr,
    output logic [DATA_W-1:0]               scr_data,
    input  logic [DATA_W-1:0]               kbd_code,
    input  logic                            kbd_valid,
    output logic                            kbd_full
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCREEN_WORDS);
    localparam int CNT_W  = $clog2(KBD_DEPTH) + 1;
    localparam int OVF_BIT = stat_ovf_bit(DATA_W);
    localparam logic [ADDR_W-1:0] MAP_SCR_BASE = ADDR_W'(RAM_WORDS);

    logic [DATA_W-1:0] ram    [RAM_WORDS];
    logic [DATA_W-1:0] screen [SCREEN_WORDS];

    region_e           region;
    logic [RAM_AW-1:0] ram_idx;
    logic [SCR_AW-1:0] scr_off;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] stat_word;

    logic [DATA_W-1:0] kbd_head;
    logic [CNT_W-1:0]  kbd_count;
    logic              kbd_empty;
    logic              kbd_overflow;
    logic              kbd_pop;
    logic              kbd_ovf_clr;

    assign region  = decode_region(32'(address), 32'(RAM_WORDS), 32'(SCREEN_WORDS));
    assign ram_idx = RAM_AW'(address);
    assign scr_off = SCR_AW'(address - MAP_SCR_BASE);

    assign kbd_pop     = load && (region == REG_KBD);
    assign kbd_ovf_clr = load && (region == REG_STAT);

    hack_memory_map_kbd_fifo #(
        .DEPTH (KBD_DEPTH),
        .WIDTH (DATA_W)
    ) u_kbd_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (kbd_valid),
        .push_data (kbd_code),
        .pop       (kbd_pop),
        .ovf_clr   (kbd_ovf_clr),
        .head      (kbd_head),
        .count     (kbd_count),
        .full      (kbd_full),
        .empty     (kbd_empty),
        .overflow  (kbd_overflow)
    );

    always_comb begin
        stat_word = '0;
        stat_word[OVF_BIT] = kbd_overflow;
        stat_word[STAT_CNT_LSB +: CNT_W] = kbd_count;
    end

    // The FIFO head is taken combinationally here, before any pop this
    // cycle advances the read pointer; an empty FIFO reads as "no key".
    always_comb begin
        rd_word = '0;
        case (region)
            REG_RAM:    rd_word = ram[ram_idx];
            REG_SCREEN: rd_word = screen[scr_off];
            REG_KBD:    rd_word = kbd_empty ? '0 : kbd_head;
            REG_STAT:   rd_word = stat_word;
            default:    rd_word = '0;
        endcase
    end

    // Array writes and the registered reads share the edge, which gives
    // read-first behaviour on a same-address read/write.
    always_ff @(posedge clock) begin
        if (load && (region == REG_RAM))
            ram[ram_idx] <= in;
        if (load && (region == REG_SCREEN))
            screen[scr_off] <= in;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out      <= '0;
            addr_err <= 1'b0;
            scr_data <= '0;
        end else begin
            out      <= rd_word;
            addr_err <= (region == REG_NONE);
            scr_data <= screen[scr_addr];
        end
    end

endmodule

// File: tb/tb_hack_memory_map.sv
// tb/tb_hack_memory_map.sv - self-checking bench for hack_memory_map against a queue/array reference model
module tb_hack_memory_map;

    localparam int RAM_N  = 16384;
    localparam int SCR_N  = 8192;
    localparam int KBD_A  = RAM_N + SCR_N;
    localparam int STAT_A = KBD_A + 1;
    localparam int DEPTH  = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] wdata = '0;
    logic [14:0] address = '0;
    logic        load = 1'b0;
    logic [15:0] rdata;
    logic        addr_err;
    logic [12:0] scr_addr = '0;
    logic [15:0] scr_data;
    logic [15:0] kbd_code = '0;
    logic        kbd_valid = 1'b0;
    logic        kbd_full;

    int checks = 0;
    int errors = 0;

    // Reference model: sparse word store for RAM+screen, queue for the keyboard.
    logic [15:0] mem_model [int];
    logic [15:0] kq [$];
    bit          ovf_model = 1'b0;

    hack_memory_map dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in        (wdata),
        .address   (address),
        .load      (load),
        .out       (rdata),
        .addr_err  (addr_err),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data),
        .kbd_code  (kbd_code),
        .kbd_valid (kbd_valid),
        .kbd_full  (kbd_full)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] stat_model();
        return {ovf_model, 11'b0, 4'(kq.size())};
    endfunction

    // One clock of CPU/display/keyboard traffic, checked against the model.
    task automatic step(input int a, input logic [15:0] d, input logic ld,
                        input logic kv, input logic [15:0] kc, input int sa);
        logic [15:0] exp_out;
        logic        exp_err;
        bit          out_known;
        bit          scr_known;
        logic [15:0] exp_scr;
        address   = 15'(a);
        wdata     = d;
        load      = ld;
        kbd_valid = kv;
        kbd_code  = kc;
        scr_addr  = 13'(sa);
        exp_err   = 1'b0;
        exp_out   = '0;
        out_known = 1'b1;
        if (a < KBD_A) begin
            out_known = mem_model.exists(a);
            if (out_known) exp_out = mem_model[a];
        end else if (a == KBD_A) begin
            exp_out = (kq.size() > 0) ? kq[0] : 16'h0000;
        end else if (a == STAT_A) begin
            exp_out = stat_model();
        end else begin
            exp_err = 1'b1;
        end
        scr_known = mem_model.exists(RAM_N + sa);
        exp_scr   = scr_known ? mem_model[RAM_N + sa] : 16'h0000;

        @(posedge clock);
        #1;

        if (ld) begin
            if (a < KBD_A) mem_model[a] = d;
            else if (a == KBD_A && kq.size() > 0) void'(kq.pop_front());
            else if (a == STAT_A) ovf_model = 1'b0;
        end
        if (kv) begin
            if (kq.size() < DEPTH) kq.push_back(kc);
            else ovf_model = 1'b1;
        end

        if (out_known) chk("out", rdata, exp_out);
        chk("addr_err", addr_err, exp_err);
        if (scr_known) chk("scr_data", scr_data, exp_scr);
        chk("kbd_full", kbd_full, kq.size() == DEPTH);
    endtask

    initial begin
        int a;
        int sa;
        int kind;
        logic ld;
        logic kv;

        #3;
        chk("rst_out", rdata, 16'h0000);
        chk("rst_scr", scr_data, 16'h0000);
        chk("rst_err", addr_err, 1'b0);
        chk("rst_full", kbd_full, 1'b0);
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;

        // RAM write then read back
        step(0, 16'd64, 1, 0, 0, 0);
        step(256, 16'd64, 1, 0, 0, 0);
        step(16383, 16'd64, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);      chk("ram0", rdata, 16'd64);
        step(256, 0, 0, 0, 0, 0);    chk("ram256", rdata, 16'd64);
        step(16383, 0, 0, 0, 0, 0);  chk("ram16383", rdata, 16'd64);
        chk("ram_err", addr_err, 1'b0);

        // Screen via CPU and display port, read-first hazard
        step(16384, 16'hAAAA, 1, 0, 0, 0);
        step(24575, 16'hAAAA, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);       chk("scr_disp0", scr_data, 16'hAAAA);
        step(0, 0, 0, 0, 0, 8191);    chk("scr_disp8191", scr_data, 16'hAAAA);
        step(24575, 16'h5555, 1, 0, 0, 8191);
        chk("scr_rdfirst", rdata, 16'hAAAA);
        chk("scr_disp_old", scr_data, 16'hAAAA);
        step(24575, 0, 0, 0, 0, 8191);
        chk("scr_new", rdata, 16'h5555);
        chk("scr_disp_new", scr_data, 16'h5555);

        // Keyboard push/read/pop
        step(0, 0, 0, 1, 16'h0041, 0);
        step(0, 0, 0, 1, 16'h0042, 0);
        step(KBD_A, 0, 0, 0, 0, 0);   chk("kbd_head41", rdata, 16'h0041);
        step(STAT_A, 0, 0, 0, 0, 0);  chk("kbd_stat2", rdata, 16'h0002);
        step(KBD_A, 0, 1, 0, 0, 0);   chk("kbd_pop_old", rdata, 16'h0041);
        step(KBD_A, 0, 0, 0, 0, 0);   chk("kbd_head42", rdata, 16'h0042);
        step(KBD_A, 0, 1, 0, 0, 0);
        step(KBD_A, 0, 1, 0, 0, 0);
        step(KBD_A, 0, 0, 0, 0, 0);   chk("kbd_empty0", rdata, 16'h0000);

        // Fill, overflow, clear, push+pop while full
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0, 1, 16'(16'h0100 + i), 0);
            if (i == 7) chk("full_after8", kbd_full, 1'b1);
        end
        step(STAT_A, 0, 0, 0, 0, 0);  chk("stat_ovf", rdata, 16'h8008);
        step(STAT_A, 0, 1, 0, 0, 0);
        step(STAT_A, 0, 0, 0, 0, 0);  chk("stat_clr", rdata, 16'h0008);
        step(KBD_A, 0, 1, 1, 16'h01F0, 0);
        step(STAT_A, 0, 0, 0, 0, 0);  chk("stat_pushpop", rdata, 16'h0008);
        step(KBD_A, 0, 0, 0, 0, 0);   chk("head_after_pp", rdata, 16'h0101);

        // Unmapped accesses
        step(24578, 16'h1234, 1, 0, 0, 0);
        chk("unm_out", rdata, 16'h0000);
        chk("unm_err", addr_err, 1'b1);
        step(32767, 16'h4321, 0, 0, 0, 0);
        chk("unm2_err", addr_err, 1'b1);
        step(0, 0, 0, 0, 0, 0);
        chk("unm_pulse", addr_err, 1'b0);
        chk("unm_ram", rdata, 16'd64);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            kind = $urandom_range(0, 9);
            ld   = 1'($urandom_range(0, 1));
            kv   = ($urandom_range(0, 2) == 0);
            case (kind)
                0, 1, 2: a = $urandom_range(0, 7) * 2047;
                3, 4:    a = RAM_N + $urandom_range(0, 7) * 1170;
                5, 6:    a = KBD_A;
                7:       a = STAT_A;
                default: a = $urandom_range(STAT_A + 1, 32767);
            endcase
            if (a == STAT_A && ld) kv = 1'b0;
            sa = $urandom_range(0, 7) * 1170;
            step(a, 16'($urandom), ld, kv, 16'($urandom), sa);
        end

        // Asynchronous reset mid-burst
        while (kq.size() > 0) step(KBD_A, 0, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 16'(16'h0200 + i), 0);
        step(16383, 0, 0, 0, 0, 0);
        chk("pre_rst_full", kbd_full, 1'b1);
        chk("pre_rst_out", rdata, 16'd64);
        load = 1'b0;
        kbd_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out", rdata, 16'h0000);
        chk("arst_scr", scr_data, 16'h0000);
        chk("arst_full", kbd_full, 1'b0);
        chk("arst_err", addr_err, 1'b0);
        kq.delete();
        ovf_model = 1'b0;
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        step(STAT_A, 0, 0, 0, 0, 0);
        chk("post_rst_stat", rdata, 16'h0000);
        step(16383, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
